// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decode fields in, forwarding sources in, ALU operands and EX control out.
// The upstream/pipeline side uses master; the stage itself uses slave.
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int STALL_CW   = 16
);
    logic                  id_valid;
    logic [REG_AW-1:0]     id_rs1;
    logic [REG_AW-1:0]     id_rs2;
    logic [REG_AW-1:0]     id_rd;
    logic [DATA_WIDTH-1:0] id_rd1;
    logic [DATA_WIDTH-1:0] id_rd2;
    logic [DATA_WIDTH-1:0] id_imm;
    logic                  id_alusrc;
    logic [2:0]            id_alucontrol;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  flush;
    logic                  mem_regwrite;
    logic [REG_AW-1:0]     mem_rd;
    logic [DATA_WIDTH-1:0] mem_result;
    logic                  wb_regwrite;
    logic [REG_AW-1:0]     wb_rd;
    logic [DATA_WIDTH-1:0] wb_result;

    logic [DATA_WIDTH-1:0] ALUSrcA;
    logic [DATA_WIDTH-1:0] ALUSrcB;
    logic [2:0]            ALUControl;
    logic                  ex_valid;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [REG_AW-1:0]     ex_rd;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic                  stall;
    logic [STALL_CW-1:0]   stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
               id_alusrc, id_alucontrol, id_regwrite, id_memread, flush,
               mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
        input  ALUSrcA, ALUSrcB, ALUControl, ex_valid, ex_regwrite, ex_memread,
               ex_rd, ex_store_data, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
               id_alusrc, id_alucontrol, id_regwrite, id_memread, flush,
               mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
        output ALUSrcA, ALUSrcB, ALUControl, ex_valid, ex_regwrite, ex_memread,
               ex_rd, ex_store_data, stall, stall_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register with MEM/WB forwarding, load-use stall/bubble insertion and a
// saturating count of inserted load-use bubbles.
module alu_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int STALL_CW   = 16
) (
    input logic                clk,
    input logic                rst,
    alu_operand_stage_if.slave bus
);
    logic                  r_valid;
    logic [REG_AW-1:0]     r_rs1;
    logic [REG_AW-1:0]     r_rs2;
    logic [REG_AW-1:0]     r_rd;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic [DATA_WIDTH-1:0] r_rd2;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_alusrc;
    logic [2:0]            r_alucontrol;
    logic                  r_regwrite;
    logic                  r_memread;
    logic [STALL_CW-1:0]   r_stall_cnt;

    logic                  w_stall;
    logic                  w_bubble;
    logic [DATA_WIDTH-1:0] w_fwd_a;
    logic [DATA_WIDTH-1:0] w_fwd_b;

    // rs2 is compared even for immediate-form instructions: conservative on purpose.
    assign w_stall = r_valid & r_memread & (r_rd != '0) & bus.id_valid &
                     ((bus.id_rs1 == r_rd) | (bus.id_rs2 == r_rd));

    assign w_bubble = bus.flush | w_stall;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid      <= 1'b0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_alusrc     <= 1'b0;
            r_alucontrol <= '0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
        end else begin
            r_valid      <= bus.id_valid;
            r_rs1        <= bus.id_rs1;
            r_rs2        <= bus.id_rs2;
            r_rd         <= bus.id_rd;
            r_rd1        <= bus.id_rd1;
            r_rd2        <= bus.id_rd2;
            r_imm        <= bus.id_imm;
            r_alusrc     <= bus.id_alusrc;
            r_alucontrol <= bus.id_alucontrol;
            r_regwrite   <= bus.id_regwrite & bus.id_valid;
            r_memread    <= bus.id_memread & bus.id_valid;
        end
    end

    // A flush-killed stall cycle is not a bubble caused by the hazard, so it is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !bus.flush && (r_stall_cnt != {STALL_CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CW'(1);
        end
    end

    // MEM is the younger producer, so it takes priority over WB; x0 never forwards.
    always_comb begin
        w_fwd_a = r_rd1;
        if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == r_rs1)) begin
            w_fwd_a = bus.mem_result;
        end else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1)) begin
            w_fwd_a = bus.wb_result;
        end
    end

    always_comb begin
        w_fwd_b = r_rd2;
        if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == r_rs2)) begin
            w_fwd_b = bus.mem_result;
        end else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == r_rs2)) begin
            w_fwd_b = bus.wb_result;
        end
    end

    assign bus.ALUSrcA       = w_fwd_a;
    assign bus.ALUSrcB       = r_alusrc ? r_imm : w_fwd_b;
    assign bus.ex_store_data = w_fwd_b;
    assign bus.ALUControl    = r_alucontrol;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_regwrite   = r_regwrite;
    assign bus.ex_memread    = r_memread;
    assign bus.ex_rd         = r_rd;
    assign bus.stall         = w_stall;
    assign bus.stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with a 2-bit counter exercises saturation.
module tb_alu_operand_stage;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int CW2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_WIDTH(DW), .REG_AW(AW), .STALL_CW(CW))  b1 ();
    alu_operand_stage_if #(.DATA_WIDTH(DW), .REG_AW(AW), .STALL_CW(CW2)) b2 ();

    alu_operand_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .STALL_CW(CW))
        u_dut (.clk(clk), .rst(rst), .bus(b1.slave));
    alu_operand_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .STALL_CW(CW2))
        u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b2.id_valid      = b1.id_valid;
    assign b2.id_rs1        = b1.id_rs1;
    assign b2.id_rs2        = b1.id_rs2;
    assign b2.id_rd         = b1.id_rd;
    assign b2.id_rd1        = b1.id_rd1;
    assign b2.id_rd2        = b1.id_rd2;
    assign b2.id_imm        = b1.id_imm;
    assign b2.id_alusrc     = b1.id_alusrc;
    assign b2.id_alucontrol = b1.id_alucontrol;
    assign b2.id_regwrite   = b1.id_regwrite;
    assign b2.id_memread    = b1.id_memread;
    assign b2.flush         = b1.flush;
    assign b2.mem_regwrite  = b1.mem_regwrite;
    assign b2.mem_rd        = b1.mem_rd;
    assign b2.mem_result    = b1.mem_result;
    assign b2.wb_regwrite   = b1.wb_regwrite;
    assign b2.wb_rd         = b1.wb_rd;
    assign b2.wb_result     = b1.wb_result;

    // Model of the instruction sitting in EX and the number of counted bubbles.
    typedef struct {
        logic          valid;
        logic [AW-1:0] rs1, rs2, rd;
        logic [DW-1:0] rd1, rd2, imm;
        logic          alusrc;
        logic [2:0]    ctrl;
        logic          regwrite, memread;
    } ex_t;

    ex_t m;
    int  m_cnt;
    int  n_total = 0;
    int  n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_stall();
        return m.valid && m.memread && (m.rd != 0) && b1.id_valid &&
               ((b1.id_rs1 == m.rd) || (b1.id_rs2 == m.rd));
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] src, input logic [DW-1:0] regval);
        if (b1.mem_regwrite && (b1.mem_rd != 0) && (b1.mem_rd == src)) return b1.mem_result;
        if (b1.wb_regwrite && (b1.wb_rd != 0) && (b1.wb_rd == src)) return b1.wb_result;
        return regval;
    endfunction

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic check_all(input string tag);
        logic [DW-1:0] fb;
        #1;
        fb = exp_fwd(m.rs2, m.rd2);
        chk({tag, "/stall"}, 64'(b1.stall), 64'(exp_stall()));
        chk({tag, "/srca"},  64'(b1.ALUSrcA), 64'(exp_fwd(m.rs1, m.rd1)));
        chk({tag, "/srcb"},  64'(b1.ALUSrcB), 64'(m.alusrc ? m.imm : fb));
        chk({tag, "/store"}, 64'(b1.ex_store_data), 64'(fb));
        chk({tag, "/ctrl"},  64'(b1.ALUControl), 64'(m.ctrl));
        chk({tag, "/valid"}, 64'(b1.ex_valid), 64'(m.valid));
        chk({tag, "/rw"},    64'(b1.ex_regwrite), 64'(m.regwrite));
        chk({tag, "/mr"},    64'(b1.ex_memread), 64'(m.memread));
        chk({tag, "/rd"},    64'(b1.ex_rd), 64'(m.rd));
        chk({tag, "/cnt"},   64'(b1.stall_cnt), 64'(sat(m_cnt, (1 << CW) - 1)));
        chk({tag, "/cnt2"},  64'(b2.stall_cnt), 64'(sat(m_cnt, (1 << CW2) - 1)));
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        ex_t nx;
        int  nc;
        logic st;
        st = exp_stall();
        nx = m;
        nc = m_cnt;
        if (rst) begin
            nx = '{default: '0};
            nc = 0;
        end else begin
            if (st && !b1.flush) nc = m_cnt + 1;
            if (b1.flush || st) begin
                nx = '{default: '0};
            end else begin
                nx.valid    = b1.id_valid;
                nx.rs1      = b1.id_rs1;
                nx.rs2      = b1.id_rs2;
                nx.rd       = b1.id_rd;
                nx.rd1      = b1.id_rd1;
                nx.rd2      = b1.id_rd2;
                nx.imm      = b1.id_imm;
                nx.alusrc   = b1.id_alusrc;
                nx.ctrl     = b1.id_alucontrol;
                nx.regwrite = b1.id_regwrite && b1.id_valid;
                nx.memread  = b1.id_memread && b1.id_valid;
            end
        end
        @(posedge clk);
        m     = nx;
        m_cnt = nc;
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                          input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                          input logic [DW-1:0] imm, input logic alusrc, input int ctrl,
                          input logic rw, input logic mr);
        b1.id_valid      = v;
        b1.id_rs1        = AW'(rs1);
        b1.id_rs2        = AW'(rs2);
        b1.id_rd         = AW'(rd);
        b1.id_rd1        = rd1;
        b1.id_rd2        = rd2;
        b1.id_imm        = imm;
        b1.id_alusrc     = alusrc;
        b1.id_alucontrol = 3'(ctrl);
        b1.id_regwrite   = rw;
        b1.id_memread    = mr;
    endtask

    task automatic set_fwd(input logic mrw, input int mrd, input logic [DW-1:0] mres,
                           input logic wrw, input int wrd, input logic [DW-1:0] wres);
        b1.mem_regwrite = mrw;
        b1.mem_rd       = AW'(mrd);
        b1.mem_result   = mres;
        b1.wb_regwrite  = wrw;
        b1.wb_rd        = AW'(wrd);
        b1.wb_result    = wres;
    endtask

    task automatic set_random();
        set_id(1'($urandom_range(1, 0) | $urandom_range(1, 0)), int'($urandom_range(7, 0)),
               int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), $urandom, $urandom,
               $urandom, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(2, 0) == 0));
        set_fwd(1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), $urandom,
                1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), $urandom);
        b1.flush = ($urandom_range(9, 0) == 0);
    endtask

    int sat_exp[5];

    initial begin
        m     = '{default: '0};
        m_cnt = 0;
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

        // Reset with random decode traffic.
        rst = 1'b1;
        set_random();
        b1.flush = 1'b0;
        tick();
        set_random();
        tick();
        check_all("rst");
        chk("rst_srca", 64'(b1.ALUSrcA), 64'd0);
        chk("rst_srcb", 64'(b1.ALUSrcB), 64'd0);
        chk("rst_stall", 64'(b1.stall), 64'd0);
        chk("rst_cnt", 64'(b1.stall_cnt), 64'd0);
        chk("rst_valid", 64'(b1.ex_valid), 64'd0);

        // Plain capture with an immediate operand.
        rst = 1'b0;
        b1.flush = 1'b0;
        set_fwd(1'b0, 0, '0, 1'b0, 0, '0);
        set_id(1'b1, 1, 2, 4, 32'd5, 32'd9, 32'd7, 1'b1, 0, 1'b1, 1'b0);
        tick();
        check_all("cap");
        chk("cap_srca", 64'(b1.ALUSrcA), 64'd5);
        chk("cap_srcb", 64'(b1.ALUSrcB), 64'd7);
        chk("cap_ctrl", 64'(b1.ALUControl), 64'd0);
        chk("cap_valid", 64'(b1.ex_valid), 64'd1);

        // Forwarding priority on rs1 = x3.
        set_id(1'b1, 3, 0, 6, 32'h11, 32'h22, 32'h0, 1'b0, 2, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 0, 0, 0, '0, '0, '0, 1'b0, 0, 1'b0, 1'b0);
        set_fwd(1'b1, 3, 32'hAA, 1'b1, 3, 32'hBB);
        check_all("fwd_mem");
        chk("fwd_mem_a", 64'(b1.ALUSrcA), 64'hAA);
        set_fwd(1'b0, 3, 32'hAA, 1'b1, 3, 32'hBB);
        check_all("fwd_wb");
        chk("fwd_wb_a", 64'(b1.ALUSrcA), 64'hBB);
        set_fwd(1'b1, 0, 32'hAA, 1'b1, 0, 32'hBB);
        check_all("fwd_x0");
        chk("fwd_x0_a", 64'(b1.ALUSrcA), 64'h11);
        set_fwd(1'b0, 0, '0, 1'b0, 0, '0);

        // Load-use on rs2: one stall cycle, a bubble, then capture.
        set_id(1'b1, 0, 0, 5, '0, '0, 32'h40, 1'b1, 0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 1, 5, 7, 32'h3, 32'h4, 32'h0, 1'b1, 1, 1'b1, 1'b0);
        check_all("lu_hz");
        chk("lu_stall", 64'(b1.stall), 64'd1);
        tick();
        check_all("lu_bub");
        chk("lu_bub_stall", 64'(b1.stall), 64'd0);
        chk("lu_bub_valid", 64'(b1.ex_valid), 64'd0);
        chk("lu_bub_cnt", 64'(b1.stall_cnt), 64'd1);
        tick();
        check_all("lu_cap");
        chk("lu_cap_valid", 64'(b1.ex_valid), 64'd1);
        chk("lu_cap_rd", 64'(b1.ex_rd), 64'd7);

        // Load to x0 never stalls.
        set_id(1'b1, 0, 0, 0, '0, '0, '0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 0, 0, 8, '0, '0, '0, 1'b0, 0, 1'b1, 1'b0);
        check_all("lu_x0");
        chk("lu_x0_stall", 64'(b1.stall), 64'd0);
        tick();

        // Flush beats stall; flush alone kills a valid decode.
        set_id(1'b1, 0, 0, 5, '0, '0, '0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5, 0, 9, '0, '0, '0, 1'b0, 0, 1'b1, 1'b0);
        b1.flush = 1'b1;
        check_all("fl_hz");
        chk("fl_stall", 64'(b1.stall), 64'd1);
        tick();
        check_all("fl_bub");
        chk("fl_valid", 64'(b1.ex_valid), 64'd0);
        chk("fl_cnt", 64'(b1.stall_cnt), 64'd1);
        tick();
        check_all("fl_only");
        chk("fl_only_valid", 64'(b1.ex_valid), 64'd0);
        chk("fl_only_rw", 64'(b1.ex_regwrite), 64'd0);
        b1.flush = 1'b0;

        // Saturation of the 2-bit counter over five hazards.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 0, 0, 5, '0, '0, '0, 1'b0, 0, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 0, 5, 6, '0, '0, '0, 1'b0, 0, 1'b1, 1'b0);
            tick();
            check_all("sat");
            chk($sformatf("sat_cnt%0d", i), 64'(b2.stall_cnt), 64'(sat_exp[i]));
            tick();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_random();
            rst = ($urandom_range(199, 0) == 0);
            check_all("rnd");
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
